// File: rtl/fifo_burst_reader.sv
// Burst read master for the async FIFO read side. It pulls burst_len words and
// replays them as a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             rd_clk,
  input  logic             res,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_underflow,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             pend, pend_last;
  logic [1:0]       occ;
  logic             wr_ptr, rd_ptr;
  logic [WIDTH-1:0] q_data [2];
  logic [1:0]       q_last;
  logic             pop, push, accept, final_read;

  assign pop        = m_valid & m_ready;
  assign push       = pend;
  assign accept     = (state == IDLE) & start;
  assign final_read = fifo_rd_en & (remaining == LEN_W'(1));

  // A read is only issued if the word it returns is guaranteed a buffer slot.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (burst_len == '0) ? FINISH : READ;
      end
      READ: begin
        if ((remaining != '0) && !fifo_empty &&
            (({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop})))
          fifo_rd_en = 1'b1;
        if (fifo_rd_en && (remaining == LEN_W'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      remaining <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend      <= fifo_rd_en;
      pend_last <= final_read;
      if (accept) remaining <= burst_len;
      else if (fifo_rd_en) remaining <= remaining - LEN_W'(1);
      if (accept) err <= 1'b0;
      else if (fifo_underflow && busy) err <= 1'b1;
    end
  end

  // Words returned by the FIFO land here one cycle after their read strobe.
  always_ff @(posedge rd_clk or posedge res) begin
    if (res) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      q_last <= 2'b00;
      for (int i = 0; i < 2; i++) q_data[i] <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= fifo_rdata;
        q_last[wr_ptr] <= pend_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = m_valid ? q_data[rd_ptr] : '0;
  assign m_last  = m_valid & q_last[rd_ptr];
  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural FIFO, stream monitor,
// table-driven bursts plus hand-written latency, stall, reset and error sequences.
module tb_fifo_burst_reader;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic             rd_clk = 1'b0;
  logic             res, start, fifo_empty, fifo_underflow, fifo_rd_en;
  logic             m_valid, m_ready, m_last, busy, done, err;
  logic [LEN_W-1:0] burst_len;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic [WIDTH-1:0] m_data;

  int checks = 0;
  int failures = 0;

  fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .rd_clk(rd_clk), .res(res), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done), .err(err)
  );

  always #5 rd_clk = ~rd_clk;

  // Behavioural FIFO: data appears on fifo_rdata the cycle after the read strobe.
  logic [WIDTH-1:0] src [0:1023];
  int   src_wr = 0;
  int   src_rd = 0;
  logic flush;
  assign fifo_empty = (src_rd == src_wr);

  always @(posedge rd_clk) begin
    if (flush) src_rd <= src_wr;
    else if (fifo_rd_en && (src_rd != src_wr)) begin
      fifo_rdata <= src[src_rd];
      src_rd     <= src_rd + 1;
    end
  end

  // Stream monitor sampled mid-cycle.
  logic             mon_clr;
  int               mon_words, mon_rdens, stall_bad, ovf_bad;
  logic [WIDTH-1:0] recv_data [0:511];
  logic             recv_last [0:511];
  logic             prev_stall, prev_last;
  logic [WIDTH-1:0] prev_data;

  always @(negedge rd_clk) begin
    if (mon_clr) begin
      mon_words  <= 0;
      mon_rdens  <= 0;
      stall_bad  <= 0;
      ovf_bad    <= 0;
      prev_stall <= 1'b0;
      prev_data  <= '0;
      prev_last  <= 1'b0;
    end else begin
      if (fifo_rd_en) mon_rdens <= mon_rdens + 1;
      if (m_valid && m_ready && (mon_words < 512)) begin
        recv_data[mon_words] <= m_data;
        recv_last[mon_words] <= m_last;
        mon_words            <= mon_words + 1;
      end
      if (prev_stall && (!m_valid || (m_data != prev_data) || (m_last != prev_last)))
        stall_bad <= stall_bad + 1;
      if ((mon_rdens + int'(fifo_rd_en)) - (mon_words + int'(m_valid && m_ready)) > 2)
        ovf_bad <= ovf_bad + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  typedef struct {
    int name_id;
    int len;
    bit toggle;
    int exp_words;
    int exp_rdens;
  } vec_t;

  vec_t vecs [4];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      src[src_wr] = WIDTH'(src_wr * 37 + 5);
      src_wr++;
    end
  endtask

  task automatic applyStimulus(input int len);
    start     = 1'b1;
    burst_len = LEN_W'(len);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    cycle();
    mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    res = 1'b1; flush = 1'b1; mon_clr = 1'b1;
    start = 1'b0; burst_len = '0; m_ready = 1'b1; fifo_underflow = 1'b0;
    cycle();
    cycle();
    res = 1'b0; flush = 1'b0; mon_clr = 1'b0;
    cycle();
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit ok);
    int cyc;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && (cyc < budget)) begin
      @(negedge rd_clk);
      if (done) ok = 1'b1;
      @(posedge rd_clk);
      #1;
      if (toggle) m_ready = ~m_ready;
      cyc++;
    end
    m_ready = 1'b1;
    cycle();
  endtask

  function automatic int data_errors(input int base, input int len);
    int bad = 0;
    for (int i = 0; i < len; i++)
      if ((recv_data[i] !== src[base + i]) || (recv_last[i] !== (i == len - 1))) bad++;
    return bad;
  endfunction

  // Records rd_en/valid/last/done/busy for cycles 0..9 after a start pulse.
  task automatic trace_burst(input int len, output logic [9:0] rd, output logic [9:0] vl,
                             output logic [9:0] lst, output logic [9:0] dn, output logic [9:0] bz);
    applyStimulus(len);
    for (int k = 0; k < 10; k++) begin
      @(negedge rd_clk);
      rd[k] = fifo_rd_en; vl[k] = m_valid; lst[k] = m_last; dn[k] = done; bz[k] = busy;
      @(posedge rd_clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] rd, vl, lst, dn, bz;
    bit ok;
    int base;

    vecs[0] = '{0, 1,   1'b0, 1,   1};
    vecs[1] = '{1, 3,   1'b1, 3,   3};
    vecs[2] = '{2, 6,   1'b1, 6,   6};
    vecs[3] = '{3, 255, 1'b0, 255, 255};

    res = 1'b1; flush = 1'b1; mon_clr = 1'b1; start = 1'b0; burst_len = '0;
    m_ready = 1'b1; fifo_underflow = 1'b0;
    #3;
    checkOutput("reset_outputs", int'({fifo_rd_en, m_valid, m_data, m_last, busy, done, err}), 0);
    do_reset();

    // 4-word burst latency trace.
    clear_mon();
    base = src_rd;
    load_words(4);
    trace_burst(4, rd, vl, lst, dn, bz);
    checkOutput("t1_rd_en_pattern", int'(rd),  int'(10'b0000011110));
    checkOutput("t1_valid_pattern", int'(vl),  int'(10'b0001111000));
    checkOutput("t1_last_pattern",  int'(lst), int'(10'b0001000000));
    checkOutput("t1_done_pattern",  int'(dn),  int'(10'b0010000000));
    checkOutput("t1_busy_pattern",  int'(bz),  int'(10'b0011111110));
    checkOutput("t1_words", mon_words, 4);
    checkOutput("t1_data", data_errors(base, 4), 0);

    // Zero-length burst.
    clear_mon();
    trace_burst(0, rd, vl, lst, dn, bz);
    checkOutput("t2_rd_en_pattern", int'(rd), 0);
    checkOutput("t2_valid_pattern", int'(vl), 0);
    checkOutput("t2_done_pattern",  int'(dn), int'(10'b0000000010));
    checkOutput("t2_busy_pattern",  int'(bz), int'(10'b0000000010));

    // Table-driven bursts, including stalls and the maximum length.
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      base = src_rd;
      load_words(vecs[v].len);
      applyStimulus(vecs[v].len);
      cycle();
      start = 1'b0;
      if (vecs[v].toggle) m_ready = 1'b0;
      wait_done(2000, vecs[v].toggle, ok);
      checkOutput($sformatf("vec%0d_done_seen", v), int'(ok), 1);
      checkOutput($sformatf("vec%0d_words", v), mon_words, vecs[v].exp_words);
      checkOutput($sformatf("vec%0d_rd_ens", v), mon_rdens, vecs[v].exp_rdens);
      checkOutput($sformatf("vec%0d_data", v), data_errors(base, vecs[v].len), 0);
      checkOutput($sformatf("vec%0d_stall_hold", v), stall_bad, 0);
      checkOutput($sformatf("vec%0d_buffer_bound", v), ovf_bad, 0);
      checkOutput($sformatf("vec%0d_idle_after", v), int'(busy), 0);
    end

    // FIFO runs dry after 2 of 5 words, refilled 10 cycles later.
    clear_mon();
    base = src_rd;
    load_words(2);
    applyStimulus(5);
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    checkOutput("t4_busy_while_empty", int'(busy), 1);
    checkOutput("t4_rd_en_stalled", mon_rdens, 2);
    checkOutput("t4_words_before_refill", mon_words, 2);
    load_words(3);
    wait_done(200, 1'b0, ok);
    checkOutput("t4_done_seen", int'(ok), 1);
    checkOutput("t4_words", mon_words, 5);
    checkOutput("t4_data", data_errors(base, 5), 0);

    // A second start mid-burst must be ignored.
    clear_mon();
    base = src_rd;
    load_words(6);
    applyStimulus(4);
    cycle();
    start = 1'b0;
    cycle();
    applyStimulus(3);
    cycle();
    start = 1'b0;
    wait_done(200, 1'b0, ok);
    checkOutput("t5_done_seen", int'(ok), 1);
    checkOutput("t5_words", mon_words, 4);
    checkOutput("t5_data", data_errors(base, 4), 0);
    checkOutput("t5_fifo_left", src_wr - src_rd, 2);
    flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Asynchronous reset in the middle of a stalled burst.
    clear_mon();
    load_words(4);
    m_ready = 1'b0;
    applyStimulus(4);
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    checkOutput("t5_valid_before_reset", int'(m_valid), 1);
    #2;
    res = 1'b1;
    #1;
    checkOutput("t5_async_reset_outputs",
                int'({fifo_rd_en, m_valid, m_data, m_last, busy, done, err}), 0);
    do_reset();
    checkOutput("t5_idle_after_reset", int'({busy, m_valid}), 0);

    // Underflow sets a sticky error that the next accepted start clears.
    clear_mon();
    load_words(3);
    applyStimulus(3);
    cycle();
    start = 1'b0;
    cycle();
    fifo_underflow = 1'b1;
    cycle();
    fifo_underflow = 1'b0;
    checkOutput("t6_err_set", int'(err), 1);
    checkOutput("t6_busy_continues", int'(busy), 1);
    wait_done(200, 1'b0, ok);
    checkOutput("t6_done_seen", int'(ok), 1);
    checkOutput("t6_words", mon_words, 3);
    checkOutput("t6_err_sticky", int'(err), 1);
    applyStimulus(0);
    cycle();
    start = 1'b0;
    checkOutput("t6_err_cleared", int'(err), 0);
    wait_done(20, 1'b0, ok);
    checkOutput("t6_second_done", int'(ok), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
